// File: rtl/div_ctrl_pkg.sv
// Shared constants and types for the divide sequencing controller.
// Used by the controller top and its iterative divider.
package div_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MSB        = DATA_WIDTH - 1;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);

    typedef logic [MSB:0] data_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam data_t SIGN_MIN = {1'b1, {MSB{1'b0}}};
    localparam data_t ALL_ONES = {DATA_WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        data_t      a;
        data_t      b;
        logic [1:0] op;
    } key_t;

    function automatic data_t abs_val(input data_t v, input logic sgn);
        return (sgn && v[MSB]) ? (~v + 1'b1) : v;
    endfunction

    function automatic data_t neg_if(input data_t v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// signs reapplied combinationally on the held result.
module div_ctrl_divider
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        flush,
    input  logic [1:0]  opcode,
    input  logic [MSB:0] a,
    input  logic [MSB:0] b,
    output logic [MSB:0] o,
    output logic        stall
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [MSB:0]     r_rem;
    logic [MSB:0]     r_quo;
    logic [MSB:0]     r_dvsr;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_rem_op;

    logic             w_signed;
    logic [DATA_WIDTH:0] w_shift;
    logic [DATA_WIDTH:0] w_diff;
    logic             w_ge;
    logic [MSB:0]     w_q_fix;
    logic [MSB:0]     w_r_fix;

    assign w_signed = ~opcode[0];

    // partial remainder stays below the divisor, so one extra bit suffices
    assign w_shift = {r_rem, r_quo[MSB]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};
    assign w_ge    = ~w_diff[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem_op <= 1'b0;
        end else if (flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (req) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(DATA_WIDTH);
            r_rem    <= '0;
            r_quo    <= abs_val(a, w_signed);
            r_dvsr   <= abs_val(b, w_signed);
            r_neg_q  <= w_signed & (a[MSB] ^ b[MSB]);
            r_neg_r  <= w_signed & a[MSB];
            r_rem_op <= opcode[1];
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
            if (w_ge) begin
                r_rem <= w_diff[MSB:0];
                r_quo <= {r_quo[MSB-1:0], 1'b1};
            end else begin
                r_rem <= w_shift[MSB:0];
                r_quo <= {r_quo[MSB-1:0], 1'b0};
            end
        end
    end

    assign w_q_fix = neg_if(r_quo, r_neg_q);
    assign w_r_fix = neg_if(r_rem, r_neg_r);
    assign o       = r_rem_op ? w_r_fix : w_q_fix;
    assign stall   = r_busy;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide controller: zero-cycle special cases and last-result
// cache, otherwise sequences the iterative divider and stalls the pipe.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic         i_flush,
    input  logic [2:0]   i_funct3,
    input  logic [MSB:0] i_a,
    input  logic [MSB:0] i_b,
    output logic [MSB:0] o_result,
    output logic         o_result_valid,
    output logic         o_stall,
    output logic         o_fast_hit
);

    state_t       r_state;
    logic         r_cache_valid;
    key_t         r_cache_key;
    logic [MSB:0] r_cache_data;
    key_t         r_pend_key;

    logic         w_div_op;
    logic [1:0]   w_opcode;
    logic         w_is_rem;
    logic         w_is_signed;
    key_t         w_key;
    logic         w_dbz;
    logic         w_ovf;
    logic         w_hit;
    logic         w_fast;
    logic [MSB:0] w_fast_res;
    logic         w_launch;
    logic         w_div_flush;
    logic [MSB:0] w_div_o;
    logic         w_div_stall;

    assign w_div_op    = i_req & i_funct3[2];
    assign w_opcode    = i_funct3[1:0];
    assign w_is_rem    = w_opcode[1];
    assign w_is_signed = ~w_opcode[0];
    assign w_key       = '{a: i_a, b: i_b, op: w_opcode};

    assign w_dbz  = (i_b == '0);
    assign w_ovf  = w_is_signed & (i_a == SIGN_MIN) & (i_b == ALL_ONES);
    assign w_hit  = r_cache_valid & (w_key == r_cache_key);
    assign w_fast = w_dbz | w_ovf | w_hit;

    always_comb begin
        w_fast_res = '0;
        if (w_dbz) begin
            w_fast_res = w_is_rem ? i_a : ALL_ONES;
        end else if (w_ovf) begin
            w_fast_res = w_is_rem ? '0 : i_a;
        end else if (w_hit) begin
            w_fast_res = r_cache_data;
        end
    end

    assign w_launch = (r_state == IDLE) & ~rst & ~i_flush
                    & w_div_op & ~w_fast;
    assign w_div_flush = (r_state == RUN) & i_flush;

    div_ctrl_divider u_div (
        .clk    (clk),
        .rst    (rst),
        .req    (w_launch),
        .flush  (w_div_flush),
        .opcode (w_opcode),
        .a      (i_a),
        .b      (i_b),
        .o      (w_div_o),
        .stall  (w_div_stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cache_valid <= 1'b0;
            r_cache_key   <= '0;
            r_cache_data  <= '0;
            r_pend_key    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state    <= RUN;
                        r_pend_key <= w_key;
                    end
                end
                RUN: begin
                    // a flush beats a completing divider: nothing retires
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else if (!w_div_stall) begin
                        r_state       <= IDLE;
                        r_cache_valid <= 1'b1;
                        r_cache_key   <= r_pend_key;
                        r_cache_data  <= w_div_o;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_result       = '0;
        o_result_valid = 1'b0;
        o_stall        = 1'b0;
        o_fast_hit     = 1'b0;
        if (!rst && !i_flush) begin
            unique case (r_state)
                IDLE: begin
                    if (w_div_op && w_fast) begin
                        o_result       = w_fast_res;
                        o_result_valid = 1'b1;
                        o_fast_hit     = 1'b1;
                    end else if (w_div_op) begin
                        o_stall = 1'b1;
                    end
                end
                RUN: begin
                    if (w_div_stall) begin
                        o_stall = 1'b1;
                    end else begin
                        o_result       = w_div_o;
                        o_result_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed cases plus random ops checked
// against an arithmetic reference with its own one-entry cache model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        flush;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o_result;
    logic        o_result_valid;
    logic        o_stall;
    logic        o_fast_hit;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (req),
        .i_flush        (flush),
        .i_funct3       (f3),
        .i_a            (a),
        .i_b            (b),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_stall        (o_stall),
        .o_fast_hit     (o_fast_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        fast;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_cnt = 0;

    bit          m_cv = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [1:0]  m_op;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endfunction

    function automatic logic [31:0] ref_calc(logic [2:0] f,
                                             logic [31:0] x,
                                             logic [31:0] y);
        bit sgn = !f[0];
        bit rem = f[1];
        logic [31:0] r;
        if (y == 0) r = rem ? x : 32'hFFFF_FFFF;
        else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            r = rem ? 32'h0 : x;
        else if (sgn)
            r = rem ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
        else
            r = rem ? x % y : x / y;
        return r;
    endfunction

    function automatic bit ref_fast(logic [2:0] f, logic [31:0] x,
                                    logic [31:0] y);
        bit ovf = !f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
        bit hit = m_cv && x == m_a && y == m_b && f[1:0] == m_op;
        return (y == 0) || ovf || hit;
    endfunction

    // monitor: pops the scoreboard whenever the DUT retires a result
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_cnt = 0;
        end else if (o_result_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=%h required=none",
                         o_result);
            end else begin
                e = q.pop_front();
                check("result", o_result, e.res);
                check("fast_hit", {31'b0, o_fast_hit}, {31'b0, e.fast});
                check("stall_cycles", stall_cnt, e.fast ? 0 : 33);
            end
            stall_cnt = 0;
        end else begin
            check("idle_result", o_result, 0);
            check("idle_fast", {31'b0, o_fast_hit}, 0);
            if (o_stall) stall_cnt++;
            else stall_cnt = 0;
        end
    end

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_result_valid && n < 100);
        if (!o_result_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=no_valid required=valid");
        end
    endtask

    task automatic issue(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        exp_t e;
        e.res  = ref_calc(f, x, y);
        e.fast = ref_fast(f, x, y);
        q.push_back(e);
        if (!e.fast) begin
            m_cv = 1'b1;
            m_a  = x;
            m_b  = y;
            m_op = f[1:0];
        end
        @(posedge clk);
        #1;
        req = 1'b1; f3 = f; a = x; b = y;
        wait_done();
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'b0, o_stall}, 0);
    endtask

    task automatic launch(logic [2:0] f, logic [31:0] x, logic [31:0] y,
                          int k);
        @(posedge clk);
        #1;
        req = 1'b1; f3 = f; a = x; b = y;
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pa = 32'd1;
        logic [31:0] pb = 32'd1;
        rst = 1'b1; req = 1'b0; flush = 1'b0;
        f3 = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", o_result, 0);
        check("rst_valid", {31'b0, o_result_valid}, 0);
        check("rst_stall", {31'b0, o_stall}, 0);
        check("rst_fast", {31'b0, o_fast_hit}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(3'b101, 32'd100, 32'd7);
        issue(3'b111, 32'd100, 32'd7);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b101, 32'd5, 32'd0);
        issue(3'b110, 32'hFFFF_FFF6, 32'd0);
        go_idle();
        issue(3'b100, -32'sd20, 32'd3);
        issue(3'b100, -32'sd20, 32'd3);
        issue(3'b110, -32'sd20, 32'd3);
        go_idle();

        // non-divide funct3 is ignored
        @(posedge clk);
        #1;
        req = 1'b1; f3 = 3'b000; a = 32'd9; b = 32'd3;
        @(negedge clk);
        check("nondiv_stall", {31'b0, o_stall}, 0);
        check("nondiv_valid", {31'b0, o_result_valid}, 0);
        go_idle();

        // flush at cycle 10 of a run: no result, cache untouched
        launch(3'b101, 32'd1000, 32'd3, 10);
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'b0, o_stall}, 0);
        check("flush_valid", {31'b0, o_result_valid}, 0);
        @(posedge clk);
        #1;
        flush = 1'b0; req = 1'b0;
        issue(3'b110, -32'sd20, 32'd3);
        issue(3'b101, 32'd9, 32'd2);
        go_idle();

        // reset at cycle 15 of a run clears state and cache
        launch(3'b101, 32'd1000, 32'd3, 15);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_result", o_result, 0);
        check("midrst_valid", {31'b0, o_result_valid}, 0);
        check("midrst_stall", {31'b0, o_stall}, 0);
        check("midrst_fast", {31'b0, o_fast_hit}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        m_cv = 1'b0;
        issue(3'b101, 32'd9, 32'd2);
        issue(3'b101, 32'd1000, 32'd3);

        for (int i = 0; i < 40; i++) begin
            rf = 3'(4 + $urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: begin ra = pa; rb = pb; end
                4: begin ra = ra >> $urandom_range(0, 31);
                         rb = rb >> $urandom_range(16, 31); end
                default: ;
            endcase
            issue(rf, ra, rb);
            pa = ra;
            pb = rb;
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative long-division divider.
- Decodes RV32M DIV/DIVU/REM/REMU (funct3 100/101/110/111) and resolves RISC-V special cases in zero extra cycles (divide-by-zero, signed overflow).
- Serves exact repeats of the last completed operation from a one-entry result cache.
- Otherwise launches the divider, holds the pipeline until the divider finishes, handles flush, and reports fast-path hits.

Parameters:
- DATA_WIDTH, 32, operand/result width; taken from core package constant.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  1  EX stage presents a divide-class instruction; held with operands stable while stall=1.
- flush  in  1  kill in-flight operation (branch/trap).
- funct3  in  3  RV32M funct3; only 1xx is a divide op; others ignored.
- a  in  DATA_WIDTH  rs1.
- b  in  DATA_WIDTH  rs2.
- result  out  DATA_WIDTH  rd value; valid when result_valid=1, else 0.
- result_valid  out  1  result completes this cycle; the pipeline advances.
- stall  out  1  freeze EX and earlier stages.
- fast_hit  out  1  one-cycle pulse when special case or cache served the op.

Behaviour:
- Reset and clocking: clk, reset rst, synchronous, active-high. Reset sets state=IDLE, cache_valid=0, result=0, result_valid=0, stall=0, fast_hit=0, and resets the divider sub-instance.
- Divide op: div_op = req & funct3[2].
- Divider opcode mapping: div_opcode = funct3[1:0]; bit0=unsigned, bit1=remainder.
- State IDLE:
  - If flush: ignore req; stay IDLE; all outputs 0.
  - Else if div_op and fast case: result_valid=1, fast_hit=1, stall=0 in the same cycle; stay IDLE; divider not requested.
  - Else if div_op: assert div_req, stall=1, go RUN.
- Fast case priority:
  1. Divide-by-zero (b==0): DIV/DIVU -> all ones; REM/REMU -> a.
  2. Signed overflow (signed op, a==1<<(DATA_WIDTH-1), b==all ones): DIV -> a; REM -> 0.
  3. Cache hit: cache_valid and {a,b,funct3[1:0]} equals the stored key -> stored result.
- State RUN:
  - div_req held low (divider latches operands on the launch cycle).
  - stall = div_stall.
  - When div_stall falls: result=div_o, result_valid=1, stall=0; write cache key and result; cache_valid=1; go IDLE.
- Latency: non-fast op returns DATA_WIDTH+1 cycles after the launch cycle (launch = cycle 0, result in cycle 33 for 32-bit). Stall is high in cycles 0..32.
- Back-to-back ops: after the result cycle the pipeline advances. The next cycle's req is a new instruction, even if operands are identical (cache then hits).
- Flush in RUN: assert div_flush; go IDLE next cycle; stall=0 and result_valid=0 in the flush cycle; cache not written.
- Flush and divider completion in the same cycle: flush wins, no result, no cache write.
- Reset mid-RUN: immediate return to IDLE; the divider's reset also clears it.
- Cache invalidation: cache_valid cleared on reset only. A flush does not invalidate, because cached data is architecturally correct.
- Non-divide funct3 with req=1: ignored; stall=0, result_valid=0.
- Outputs are combinational from state plus registered cache/divider output. No comb path from result to req.

Decomposition:
- Core package (core.svh): DATA_WIDTH/DATA_RANGE, funct3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111, and a 1-bit state enum (IDLE, RUN).
- Sub-module: one instance of the existing divider (ports clk, rst, req, flush, opcode[1:0], a, b, o, stall).
- Fast-case detection and the cache comparator stay inline.

Test Plan:
- DIVU a=100, b=7 -> stall high 33 cycles, then result=14, result_valid=1, fast_hit=0. Follow with REMU 100,7 -> result=2 after 33 stall cycles.
- DIV a=0x80000000, b=0xFFFFFFFF -> same-cycle result=0x80000000, fast_hit=1, stall=0. REM on the same operands -> result=0.
- DIVU a=5, b=0 -> same cycle 0xFFFFFFFF. REM a=0xFFFFFFF6, b=0 -> 0xFFFFFFF6; no divider launch.
- DIV a=-20, b=3 -> result=0xFFFFFFFA after 33 cycles. Immediate repeat DIV -20,3 -> same-cycle 0xFFFFFFFA via cache, fast_hit=1. Then REM -20,3 -> full run, result 0xFFFFFFFE.
- Launch DIVU 1000,3; flush at cycle 10 -> stall drops that cycle, no result_valid, cache unchanged. New DIVU 9,2 -> 4 after 33 cycles.
- Reset asserted at cycle 15 of a run -> state IDLE, all outputs 0. Next op DIVU 1000,3 misses the cache and returns 333.
